keyboard_event_ctrl: RTL and testbench
======================================

Name: keyboard_event_ctrl

Overview:
- Sequences the PS/2 scan-code byte stream coming from the keyboard receiver into complete key events.
- Decodes the E0 (extended), F0 (break) and E1 (pause) prefix sequences with a parser FSM.
- Queues decoded events in a small FIFO and presents the head event to the CPU-side I/O registers (key_status/keycode) with a pop handshake.
- Sits between the PS/2 receiver and the CPU I/O bus, replacing direct use of raw driver outputs.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 events (8).
- TIMEOUT, 100000, idle clk cycles after which a partial prefix sequence is abandoned; must be < 2**20.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- rx_data  input  8  scan-code byte from PS/2 receiver
- rx_valid  input  1  one-cycle strobe, rx_data valid
- rd_en  input  1  CPU pop strobe, one cycle per event consumed
- key_status  output  8  [0]=break, [1]=extended, [2]=valid (FIFO non-empty), [3]=overflow sticky, [4]=error sticky, [7:5]=0
- keycode  output  8  scan code of head event, 0 when empty

Behaviour:
- Reset (synchronous, active-high):
  - FSM to IDLE, FIFO emptied, timeout counter 0, skip counter 0.
  - Sticky overflow/error flags cleared.
  - key_status=8'h00, keycode=8'h00.
  - rst overrides rx_valid/rd_en in the same cycle, including mid-sequence.
- Parser FSM, evaluated only on rx_valid; states IDLE, EXT, BRK, EXT_BRK, SKIP:
  - IDLE: E0->EXT; F0->BRK; E1->SKIP, skip counter=7; 00/FF->set error, stay IDLE; other byte b->push {ext=0,brk=0,b}.
  - EXT: E0->stay; F0->EXT_BRK; 00/FF->error, IDLE; other b->push {1,0,b}, IDLE.
  - BRK: 00/FF->error, IDLE; any other b (including E0/F0)->push {0,1,b}, IDLE.
  - EXT_BRK: 00/FF->error, IDLE; other b->push {1,1,b}, IDLE.
  - SKIP: each byte decrements skip counter, no decoding, no error check. When the counter reaches 0 (the 7th byte), push {0,0,8'hE1}, IDLE. One event per Pause press.
- Timeout:
  - 20-bit counter clears on every rx_valid and whenever the FSM is in IDLE.
  - Otherwise it increments each cycle.
  - When it reaches TIMEOUT: FSM->IDLE, nothing pushed, error set.
- FIFO:
  - 10-bit entries {ext,brk,code}, first-word-fall-through.
  - Push at the edge where the completing byte is sampled (edge N). Head is visible on outputs from cycle N+1; key_status[2]=1 from N+1 when previously empty.
  - Pop on rd_en at edge M; next head (or empty values) is visible from M+1.
  - rd_en while empty: ignored, no pointer change.
  - Push while full and no pop: event dropped, overflow set.
  - Push and pop in the same cycle: both performed, including when full (count unchanged, no overflow) and when empty (push only, the pop is ignored).
  - Pointers wrap modulo depth. Count is DEPTH_LOG2+1 bits; full when count==2**DEPTH_LOG2.
- Sticky flags: overflow and error clear on any accepted pop, or rst. A set and a clear in the same cycle resolve to set.
- Empty FIFO: keycode=0, key_status[1:0]=0. Flags still reflect their sticky values.
- All outputs are registered or driven directly from FIFO storage and pointers; no combinational path from rx_* to outputs.

Test Plan:
- Reset then rx bytes 1C -> next cycle key_status=8'h04, keycode=8'h1C; rd_en pulse -> key_status=8'h00, keycode=8'h00.
- Bytes E0,F0,75 -> single event, key_status=8'h07, keycode=8'h75. Bytes F0,1C -> key_status=8'h05.
- Pause sequence E1,14,77,E1,F0,14,F0,77 -> exactly one event, keycode=8'hE1, key_status=8'h04; FSM back in IDLE (next byte 1C produces a make event).
- Push 9 make events 01..09 with no reads -> valid, overflow set (key_status=8'h0C, keycode=01). Pop 8 times and see codes 01..08; overflow cleared after the first pop; 09 never appears.
- Byte E0, then silence for TIMEOUT cycles, then 1C -> error bit set; event {ext=0,brk=0,1C}, key_status=8'h14.
- Byte F0, assert rst on the next rx_valid cycle carrying 1C -> no event; key_status=8'h00 after reset. FIFO full with simultaneous rx push and rd_en -> count stays 8, no overflow.

Source files
------------

// File: rtl/keyboard_event_ctrl_if.sv
// Byte-stream and CPU register bundle for keyboard_event_ctrl.
// master = receiver/CPU side driving bytes and pops; slave = the controller.
interface keyboard_event_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rd_en;
   logic [7:0] key_status;
   logic [7:0] keycode;

   modport master (
      output rx_data,
      output rx_valid,
      output rd_en,
      input  key_status,
      input  keycode
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  rd_en,
      output key_status,
      output keycode
   );
endinterface

// File: rtl/keyboard_event_ctrl.sv
// PS/2 scan-code sequencer: prefix parser FSM feeding a first-word-fall-through
// event FIFO that is presented to the CPU as key_status/keycode.
module keyboard_event_ctrl #(
   parameter int unsigned DEPTH_LOG2 = 3,
   parameter int unsigned TIMEOUT    = 100000
) (
   input logic                  clk,
   input logic                  rst,
   keyboard_event_ctrl_if.slave bus
);

   localparam int unsigned             DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]     DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [19:0]             TMO       = 20'(TIMEOUT);
   localparam logic [2:0]              SKIP_LEN  = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK,
      SKIP
   } state_t;

   state_t      state, next_state;
   logic [2:0]  skip_cnt, next_skip;
   logic [19:0] tmo_cnt;
   logic        tmo_hit;

   logic        push;
   logic [9:0]  push_ev;
   logic        err_set;
   logic        bad_byte;

   logic [9:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  empty, full;
   logic                  pop_ok, push_ok, ovf_set;
   logic                  ovf_flag, err_flag;
   logic [9:0]            head;

   assign bad_byte = (bus.rx_data == 8'h00) || (bus.rx_data == 8'hFF);
   assign tmo_hit  = (state != IDLE) && !bus.rx_valid && (tmo_cnt == TMO);

   // ---------------------------------------------------------------- parser
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         skip_cnt <= '0;
         tmo_cnt  <= '0;
      end else begin
         state    <= next_state;
         skip_cnt <= next_skip;
         if (bus.rx_valid || state == IDLE || tmo_hit)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      next_skip  = skip_cnt;
      push       = 1'b0;
      push_ev    = '0;
      err_set    = 1'b0;

      if (bus.rx_valid) begin
         unique case (state)
            IDLE: begin
               if (bus.rx_data == 8'hE0) begin
                  next_state = EXT;
               end else if (bus.rx_data == 8'hF0) begin
                  next_state = BRK;
               end else if (bus.rx_data == 8'hE1) begin
                  next_state = SKIP;
                  next_skip  = SKIP_LEN;
               end else if (bad_byte) begin
                  err_set = 1'b1;
               end else begin
                  push    = 1'b1;
                  push_ev = {2'b00, bus.rx_data};
               end
            end
            EXT: begin
               if (bus.rx_data == 8'hE0) begin
                  next_state = EXT;
               end else if (bus.rx_data == 8'hF0) begin
                  next_state = EXT_BRK;
               end else if (bad_byte) begin
                  err_set    = 1'b1;
                  next_state = IDLE;
               end else begin
                  push       = 1'b1;
                  push_ev    = {2'b10, bus.rx_data};
                  next_state = IDLE;
               end
            end
            BRK: begin
               next_state = IDLE;
               if (bad_byte) begin
                  err_set = 1'b1;
               end else begin
                  push    = 1'b1;
                  push_ev = {2'b01, bus.rx_data};
               end
            end
            EXT_BRK: begin
               next_state = IDLE;
               if (bad_byte) begin
                  err_set = 1'b1;
               end else begin
                  push    = 1'b1;
                  push_ev = {2'b11, bus.rx_data};
               end
            end
            SKIP: begin
               // Pause payload is swallowed whole; only its last byte emits.
               next_skip = skip_cnt - 1'b1;
               if (skip_cnt == 3'd1) begin
                  push       = 1'b1;
                  push_ev    = {2'b00, 8'hE1};
                  next_state = IDLE;
               end
            end
            default: begin
               next_state = IDLE;
            end
         endcase
      end else if (tmo_hit) begin
         next_state = IDLE;
         err_set    = 1'b1;
      end
   end

   // ------------------------------------------------------------------ FIFO
   assign empty   = (count == '0);
   assign full    = (count == DEPTH_CNT);
   assign pop_ok  = bus.rd_en && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign ovf_set = push && full && !pop_ok;

   always_ff @(posedge clk) begin
      if (!rst && push_ok)
         mem[wr_ptr] <= push_ev;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Set beats clear when both land on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_flag <= 1'b0;
         err_flag <= 1'b0;
      end else begin
         if (ovf_set)
            ovf_flag <= 1'b1;
         else if (pop_ok)
            ovf_flag <= 1'b0;
         if (err_set)
            err_flag <= 1'b1;
         else if (pop_ok)
            err_flag <= 1'b0;
      end
   end

   // --------------------------------------------------------------- outputs
   assign head           = mem[rd_ptr];
   assign bus.keycode    = empty ? 8'h00 : head[7:0];
   assign bus.key_status = {3'b000, err_flag, ovf_flag, !empty,
                            empty ? 2'b00 : head[9:8]};

endmodule

// File: tb/tb_keyboard_event_ctrl.sv
// Self-checking bench for keyboard_event_ctrl: directed plan items plus random
// byte/pop traffic compared against a sequence-grammar reference model.
module tb_keyboard_event_ctrl;

   localparam int unsigned TMO = 64;

   logic clk;
   logic rst;
   keyboard_event_ctrl_if bus ();

   keyboard_event_ctrl #(
      .DEPTH_LOG2 (3),
      .TIMEOUT    (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: bytes of the current unfinished sequence, event queue, flags.
   logic [7:0] pend [$];
   logic [9:0] q    [$];
   logic       m_ovf;
   logic       m_err;

   function automatic void model_byte(input logic [7:0] b, output logic got,
                                      output logic [9:0] ev, output logic err);
      int k;
      got = 1'b0;
      ev  = '0;
      err = 1'b0;
      pend.push_back(b);
      if (pend[0] == 8'hE1) begin
         if (pend.size() == 8) begin
            got = 1'b1;
            ev  = {2'b00, 8'hE1};
            pend.delete();
         end
         return;
      end
      if (b == 8'h00 || b == 8'hFF) begin
         err = 1'b1;
         pend.delete();
         return;
      end
      k = 0;
      while (k < pend.size() && pend[k] == 8'hE0) k++;
      if (k == pend.size()) return;
      if (pend[k] == 8'hF0) begin
         if (pend.size() == k + 1) return;
         ev = {(k > 0), 1'b1, pend[k+1]};
      end else begin
         ev = {(k > 0), 1'b0, pend[k]};
      end
      got = 1'b1;
      pend.delete();
   endfunction

   function automatic void model_cycle(input logic v, input logic [7:0] d, input logic r);
      logic       got, err, pop_ok, was_full;
      logic [9:0] ev;
      got = 1'b0;
      err = 1'b0;
      ev  = '0;
      if (v) model_byte(d, got, ev, err);
      pop_ok   = r && (q.size() != 0);
      was_full = (q.size() == 8);
      if (pop_ok) begin
         void'(q.pop_front());
         m_ovf = 1'b0;
         m_err = 1'b0;
      end
      if (got) begin
         if (was_full && !pop_ok) m_ovf = 1'b1;
         else q.push_back(ev);
      end
      if (err) m_err = 1'b1;
   endfunction

   function automatic logic [7:0] exp_status();
      logic [1:0] eb;
      eb = (q.size() != 0) ? q[0][9:8] : 2'b00;
      return {3'b000, m_err, m_ovf, (q.size() != 0), eb};
   endfunction

   function automatic logic [7:0] exp_code();
      return (q.size() != 0) ? q[0][7:0] : 8'h00;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive one cycle, then check at the following negedge.
   task automatic step(input logic v, input logic [7:0] d, input logic r, input string tag);
      bus.rx_valid = v;
      bus.rx_data  = d;
      bus.rd_en    = r;
      model_cycle(v, d, r);
      @(posedge clk);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rd_en    = 1'b0;
      check({tag, "_status"}, bus.key_status, exp_status());
      check({tag, "_code"}, bus.keycode, exp_code());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset(input logic v, input logic [7:0] d);
      rst          = 1'b1;
      bus.rx_valid = v;
      bus.rx_data  = d;
      bus.rd_en    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst          = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rd_en    = 1'b0;
      pend.delete();
      q.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
      check("reset_status", bus.key_status, 8'h00);
      check("reset_code", bus.keycode, 8'h00);
   endtask

   logic [7:0] specials [7];

   initial begin
      rst          = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rd_en    = 1'b0;
      m_ovf        = 1'b0;
      m_err        = 1'b0;
      specials     = '{8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hFF, 8'hE0, 8'hF0};
      @(negedge clk);
      do_reset(1'b0, 8'h00);

      // Simple make then pop
      step(1'b1, 8'h1C, 1'b0, "make");
      check("make_ks", bus.key_status, 8'h04);
      check("make_kc", bus.keycode, 8'h1C);
      step(1'b0, 8'h00, 1'b1, "pop");
      check("pop_ks", bus.key_status, 8'h00);

      // Extended break and plain break
      step(1'b1, 8'hE0, 1'b0, "eb0");
      step(1'b1, 8'hF0, 1'b0, "eb1");
      check("eb_pending", bus.key_status, 8'h00);
      step(1'b1, 8'h75, 1'b0, "eb2");
      check("extbrk_ks", bus.key_status, 8'h07);
      check("extbrk_kc", bus.keycode, 8'h75);
      step(1'b0, 8'h00, 1'b1, "eb_pop");
      step(1'b1, 8'hF0, 1'b0, "b0");
      step(1'b1, 8'h1C, 1'b0, "b1");
      check("brk_ks", bus.key_status, 8'h05);
      step(1'b0, 8'h00, 1'b1, "b_pop");

      // Pause sequence, then a make to show the parser is back in IDLE
      begin
         logic [7:0] pz [8];
         pz = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
         for (int i = 0; i < 8; i++) step(1'b1, pz[i], 1'b0, "pause");
      end
      check("pause_ks", bus.key_status, 8'h04);
      check("pause_kc", bus.keycode, 8'hE1);
      step(1'b1, 8'h1C, 1'b0, "after_pause");
      step(1'b0, 8'h00, 1'b1, "pause_pop");
      check("after_pause_ks", bus.key_status, 8'h04);
      check("after_pause_kc", bus.keycode, 8'h1C);
      step(1'b0, 8'h00, 1'b1, "pause_pop2");

      // Overflow: nine makes, no reads
      for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0, "fill");
      check("ovf_ks", bus.key_status, 8'h0C);
      check("ovf_kc", bus.keycode, 8'h01);
      for (int i = 1; i <= 8; i++) begin
         check("drain_kc", bus.keycode, 8'(i));
         step(1'b0, 8'h00, 1'b1, "drain");
      end
      check("drained_ks", bus.key_status, 8'h00);

      // Timeout of a partial prefix
      step(1'b1, 8'hE0, 1'b0, "tmo_pre");
      idle(TMO - 3);
      check("tmo_before", bus.key_status, 8'h00);
      idle(8);
      pend.delete();
      m_err = 1'b1;
      check("tmo_err", bus.key_status, 8'h10);
      step(1'b1, 8'h1C, 1'b0, "tmo_make");
      check("tmo_ks", bus.key_status, 8'h14);
      check("tmo_kc", bus.keycode, 8'h1C);

      // Reset mid-sequence overrides the completing byte
      step(1'b1, 8'hF0, 1'b0, "rst_pre");
      do_reset(1'b1, 8'h1C);
      step(1'b1, 8'h1C, 1'b0, "rst_post");
      check("rst_post_ks", bus.key_status, 8'h04);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 7; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, "fill2");
      step(1'b1, 8'h2A, 1'b1, "full_pushpop");
      check("full_pushpop_ks", bus.key_status, 8'h04);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, "drain2");
      check("drain2_ks", bus.key_status, 8'h00);

      // Pop on empty with simultaneous push
      step(1'b1, 8'h55, 1'b1, "empty_pushpop");
      check("empty_pushpop_kc", bus.keycode, 8'h55);
      step(1'b0, 8'h00, 1'b1, "empty_pop");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic       v, r;
         logic [7:0] d;
         v = ($urandom_range(0, 1) == 1);
         r = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) d = specials[$urandom_range(0, 6)];
         else d = 8'($urandom_range(1, 254));
         step(v, d, r, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
